// File: rtl/dqpsk_demod_decoder.sv
// DQPSK receive back end: one decision sample per symbol, quadrant slice, differential decode,
// Gray demap, dibit-to-NRZ serialiser. Optional weak-symbol detector under DQPSK_WEAK_DET_EN.
module dqpsk_demod_decoder #(
  parameter int DW     = 16,
  parameter int SPS    = 8,
  parameter int PHASE  = 4,
  parameter int THRESH = 512
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic signed [DW-1:0] di_in,
  input  logic signed [DW-1:0] dq_in,
  input  logic                 in_valid,
  output logic                 sym_valid,
  output logic [1:0]           sym_dibit,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 sym_weak
);

  localparam int CW = (SPS > 2) ? $clog2(SPS) : 1;
  localparam logic [CW-1:0] PH   = CW'(PHASE);
  localparam logic [CW-1:0] B0PH = CW'((PHASE + SPS/2) % SPS);
  localparam logic [CW-1:0] LAST = CW'(SPS - 1);

  if (SPS < 2 || (SPS % 2) != 0 || PHASE >= SPS) begin : g_bad_cfg
    $error("dqpsk_demod_decoder: SPS must be even and >=2, PHASE < SPS");
  end

  typedef enum logic {ACQ, RUN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    q_prev_q, q_prev_d;
  logic          sym_valid_q, sym_valid_d;
  logic [1:0]    sym_dibit_q, sym_dibit_d;
  logic          dout_q, dout_d;
  logic          dout_valid_q, dout_valid_d;
  logic          b0_q, b0_d;
  logic          b0_pend_q, b0_pend_d;

  logic       dec_ev;
  logic [1:0] quad, diff, dibit;

  // Sign bits alone give the quadrant; zero counts as positive.
  assign quad   = {dq_in[DW-1], di_in[DW-1] ^ dq_in[DW-1]};
  assign diff   = quad - q_prev_q;
  assign dibit  = {diff[1], diff[1] ^ diff[0]};
  assign dec_ev = in_valid && (cnt_q == PH);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    q_prev_d     = q_prev_q;
    sym_valid_d  = 1'b0;
    sym_dibit_d  = sym_dibit_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    b0_d         = b0_q;
    b0_pend_d    = b0_pend_q;
    if (in_valid) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      if (dec_ev) begin
        q_prev_d = quad;
        if (state_q == ACQ) begin
          state_d = RUN;
        end else begin
          sym_valid_d  = 1'b1;
          sym_dibit_d  = dibit;
          dout_d       = dibit[1];
          dout_valid_d = 1'b1;
          b0_d         = dibit[0];
          b0_pend_d    = 1'b1;
        end
      end else if (b0_pend_q && cnt_q == B0PH) begin
        // b0 goes out half a symbol after b1 to keep the NRZ rate uniform
        dout_d       = b0_q;
        dout_valid_d = 1'b1;
        b0_pend_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ACQ;
      cnt_q        <= '0;
      q_prev_q     <= '0;
      sym_valid_q  <= 1'b0;
      sym_dibit_q  <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      b0_q         <= 1'b0;
      b0_pend_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      q_prev_q     <= q_prev_d;
      sym_valid_q  <= sym_valid_d;
      sym_dibit_q  <= sym_dibit_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      b0_q         <= b0_d;
      b0_pend_q    <= b0_pend_d;
    end
  end

  assign sym_valid  = sym_valid_q;
  assign sym_dibit  = sym_dibit_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef DQPSK_WEAK_DET_EN
  localparam logic [DW:0] TH = (DW+1)'(THRESH);

  logic [DW:0] abs_i, abs_q;
  logic        weak;
  logic        sym_weak_q, sym_weak_d;

  // One extra bit so the most negative sample's magnitude is representable.
  always_comb begin
    abs_i = {di_in[DW-1], di_in};
    if (abs_i[DW]) abs_i = ~abs_i + 1'b1;
    abs_q = {dq_in[DW-1], dq_in};
    if (abs_q[DW]) abs_q = ~abs_q + 1'b1;
    weak       = (abs_i < TH) && (abs_q < TH);
    sym_weak_d = dec_ev ? weak : sym_weak_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sym_weak_q <= 1'b0;
    else          sym_weak_q <= sym_weak_d;
  end

  assign sym_weak = sym_weak_q;
`else
  logic unused_mag;
  assign unused_mag = ^{di_in[DW-2:0], dq_in[DW-2:0]};
  assign sym_weak   = 1'b0;
`endif

endmodule

// File: tb/tb_dqpsk_demod_decoder.sv
// Directed self-checking bench for dqpsk_demod_decoder: latency, differential decode,
// in_valid gating, mid-symbol reset, zero-as-positive slicing and the weak-symbol flag.
module tb_dqpsk_demod_decoder;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic signed [DW-1:0] di_in, dq_in;
  logic                 in_valid;
  logic                 sym_valid, dout, dout_valid, sym_weak;
  logic [1:0]           sym_dibit;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  int         sv_cyc[$];
  logic [1:0] sv_dib[$];
  logic       sv_wk[$];
  int         dv_cyc[$];
  logic       dv_bit[$];

  always #5 clk = ~clk;

  dqpsk_demod_decoder #(.DW(DW), .SPS(8), .PHASE(4), .THRESH(512)) dut (
    .clk(clk), .reset_n(reset_n), .di_in(di_in), .dq_in(dq_in), .in_valid(in_valid),
    .sym_valid(sym_valid), .sym_dibit(sym_dibit), .dout(dout), .dout_valid(dout_valid),
    .sym_weak(sym_weak)
  );

  function automatic int qi(input int qd);
    return (qd == 1 || qd == 2) ? -1000 : 1000;
  endfunction
  function automatic int qq(input int qd);
    return (qd >= 2) ? -1000 : 1000;
  endfunction

  // One clock: apply inputs, then log any strobes seen after the edge.
  task automatic drive(input int i, input int q, input logic v);
    di_in = DW'(i); dq_in = DW'(q); in_valid = v;
    @(posedge clk); #1; cyc++;
    if (sym_valid) begin sv_cyc.push_back(cyc); sv_dib.push_back(sym_dibit); sv_wk.push_back(sym_weak); end
    if (dout_valid) begin dv_cyc.push_back(cyc); dv_bit.push_back(dout); end
  endtask

  task automatic send_sym(input int qd, input int n);
    for (int k = 0; k < n; k++) drive(qi(qd), qq(qd), 1'b1);
  endtask

  task automatic clear_log();
    sv_cyc.delete(); sv_dib.delete(); sv_wk.delete(); dv_cyc.delete(); dv_bit.delete(); cyc = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; di_in = '0; dq_in = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_log();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; di_in = '0; dq_in = '0;
    #2;
    n_chk++; if (sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sym_valid: got %b want 0", sym_valid); end
    n_chk++; if (sym_dibit !== 2'b00) begin n_fail++; $display("FAIL reset_sym_dibit: got %b want 00", sym_dibit); end
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b want 0", dout); end
    n_chk++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b want 0", dout_valid); end
    n_chk++; if (sym_weak !== 1'b0) begin n_fail++; $display("FAIL reset_sym_weak: got %b want 0", sym_weak); end
  endtask

  task automatic test_constant();
    do_reset();
    repeat (4) send_sym(0, 8);
    drive(1000, 1000, 1'b1);
    n_chk++; if (sv_cyc.size() != 3) begin n_fail++; $display("FAIL const_sym_count: got %0d want 3", sv_cyc.size()); end
    for (int k = 0; k < 3 && k < sv_cyc.size(); k++) begin
      n_chk++; if (sv_cyc[k] != 13 + 8*k) begin n_fail++; $display("FAIL const_sym_cycle[%0d]: got %0d want %0d", k, sv_cyc[k], 13 + 8*k); end
      n_chk++; if (sv_dib[k] !== 2'b00) begin n_fail++; $display("FAIL const_dibit[%0d]: got %b want 00", k, sv_dib[k]); end
    end
    n_chk++; if (dv_cyc.size() != 6) begin n_fail++; $display("FAIL const_bit_count: got %0d want 6", dv_cyc.size()); end
    for (int k = 0; k < 6 && k < dv_cyc.size(); k++) begin
      n_chk++; if (dv_cyc[k] != 13 + 4*k) begin n_fail++; $display("FAIL const_bit_cycle[%0d]: got %0d want %0d", k, dv_cyc[k], 13 + 4*k); end
      n_chk++; if (dv_bit[k] !== 1'b0) begin n_fail++; $display("FAIL const_bit[%0d]: got %b want 0", k, dv_bit[k]); end
    end
  endtask

  task automatic test_diff();
    int         seq  [3][5] = '{'{0, 1, 2, 3, 0}, '{0, 2, 0, 0, 0}, '{0, 3, 0, 0, 0}};
    int         len  [3]    = '{5, 3, 2};
    logic [1:0] expd [3][4] = '{'{2'b01, 2'b01, 2'b01, 2'b01}, '{2'b11, 2'b11, 2'b00, 2'b00},
                                '{2'b10, 2'b00, 2'b00, 2'b00}};
    for (int c = 0; c < 3; c++) begin
      do_reset();
      for (int s = 0; s < len[c]; s++) send_sym(seq[c][s], 8);
      drive(1000, 1000, 1'b1);
      n_chk++; if (sv_dib.size() != len[c] - 1) begin n_fail++; $display("FAIL diff%0d_sym_count: got %0d want %0d", c, sv_dib.size(), len[c] - 1); end
      for (int k = 0; k < len[c] - 1 && k < sv_dib.size(); k++) begin
        n_chk++; if (sv_dib[k] !== expd[c][k]) begin n_fail++; $display("FAIL diff%0d_dibit[%0d]: got %b want %b", c, k, sv_dib[k], expd[c][k]); end
      end
      n_chk++; if (dv_bit.size() != 2*(len[c] - 1)) begin n_fail++; $display("FAIL diff%0d_bit_count: got %0d want %0d", c, dv_bit.size(), 2*(len[c] - 1)); end
      for (int k = 0; k < 2*(len[c] - 1) && k < dv_bit.size(); k++) begin
        n_chk++; if (dv_bit[k] !== expd[c][k/2][1 - (k%2)]) begin n_fail++; $display("FAIL diff%0d_bit[%0d]: got %b want %b", c, k, dv_bit[k], expd[c][k/2][1 - (k%2)]); end
      end
    end
  endtask

  task automatic test_gaps();
    do_reset();
    for (int k = 0; k < 32; k++) begin drive(1000, 1000, 1'b1); drive(1000, 1000, 1'b0); end
    drive(1000, 1000, 1'b1);
    n_chk++; if (sv_cyc.size() != 3) begin n_fail++; $display("FAIL gap_sym_count: got %0d want 3", sv_cyc.size()); end
    for (int k = 0; k < 3 && k < sv_cyc.size(); k++) begin
      n_chk++; if (sv_cyc[k] != 25 + 16*k) begin n_fail++; $display("FAIL gap_sym_cycle[%0d]: got %0d want %0d", k, sv_cyc[k], 25 + 16*k); end
      n_chk++; if (sv_dib[k] !== 2'b00) begin n_fail++; $display("FAIL gap_dibit[%0d]: got %b want 00", k, sv_dib[k]); end
    end
    n_chk++; if (dv_cyc.size() != 6) begin n_fail++; $display("FAIL gap_bit_count: got %0d want 6", dv_cyc.size()); end
    for (int k = 0; k < 6 && k < dv_cyc.size(); k++) begin
      n_chk++; if (dv_cyc[k] != 25 + 8*k) begin n_fail++; $display("FAIL gap_bit_cycle[%0d]: got %0d want %0d", k, dv_cyc[k], 25 + 8*k); end
      n_chk++; if (dv_bit[k] !== 1'b0) begin n_fail++; $display("FAIL gap_bit[%0d]: got %b want 0", k, dv_bit[k]); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_sym(0, 8);
    send_sym(2, 5);
    drive(qi(2), qq(2), 1'b1);
    n_chk++; if (sv_cyc.size() != 1) begin n_fail++; $display("FAIL mid_pre_sym_count: got %0d want 1", sv_cyc.size()); end
    n_chk++; if (dout !== 1'b1) begin n_fail++; $display("FAIL mid_pre_dout_hold: got %b want 1", dout); end
    n_chk++; if (sym_dibit !== 2'b11) begin n_fail++; $display("FAIL mid_pre_dibit_hold: got %b want 11", sym_dibit); end
    reset_n = 1'b0;
    #1;
    n_chk++; if (dout !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dout: got %b want 0", dout); end
    n_chk++; if (sym_dibit !== 2'b00) begin n_fail++; $display("FAIL mid_rst_dibit: got %b want 00", sym_dibit); end
    n_chk++; if (sym_valid !== 1'b0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_strobes: got %b%b want 00", sym_valid, dout_valid); end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    clear_log();
    send_sym(0, 8);
    send_sym(1, 5);
    n_chk++; if (sv_cyc.size() != 1) begin n_fail++; $display("FAIL mid_post_sym_count: got %0d want 1", sv_cyc.size()); end
    if (sv_cyc.size() > 0) begin
      n_chk++; if (sv_cyc[0] != 13) begin n_fail++; $display("FAIL mid_post_sym_cycle: got %0d want 13", sv_cyc[0]); end
      n_chk++; if (sv_dib[0] !== 2'b01) begin n_fail++; $display("FAIL mid_post_dibit: got %b want 01", sv_dib[0]); end
    end
    n_chk++; if (dv_cyc.size() != 1) begin n_fail++; $display("FAIL mid_post_bit_count: got %0d want 1", dv_cyc.size()); end
    if (dv_cyc.size() > 0) begin
      n_chk++; if (dv_cyc[0] != 13 || dv_bit[0] !== 1'b0) begin n_fail++; $display("FAIL mid_post_bit: got cyc %0d bit %b want cyc 13 bit 0", dv_cyc[0], dv_bit[0]); end
    end
  endtask

  task automatic test_zero_sign();
    logic [1:0] expd [2] = '{2'b10, 2'b11};
    do_reset();
    send_sym(0, 8);
    repeat (8) drive(0, -1, 1'b1);
    repeat (8) drive(-1, 0, 1'b1);
    drive(1000, 1000, 1'b1);
    n_chk++; if (sv_dib.size() != 2) begin n_fail++; $display("FAIL zero_sym_count: got %0d want 2", sv_dib.size()); end
    for (int k = 0; k < 2 && k < sv_dib.size(); k++) begin
      n_chk++; if (sv_dib[k] !== expd[k]) begin n_fail++; $display("FAIL zero_dibit[%0d]: got %b want %b", k, sv_dib[k], expd[k]); end
    end
  endtask

  task automatic test_weak();
    int         vi   [3] = '{300, 600, -32768};
    int         vq   [3] = '{-400, 10, 100};
    logic [1:0] expd [3] = '{2'b10, 2'b01, 2'b01};
`ifdef DQPSK_WEAK_DET_EN
    logic       expw [3] = '{1'b1, 1'b0, 1'b0};
`else
    logic       expw [3] = '{1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    send_sym(0, 8);
    for (int s = 0; s < 3; s++) repeat (8) drive(vi[s], vq[s], 1'b1);
    drive(1000, 1000, 1'b1);
    n_chk++; if (sv_wk.size() != 3) begin n_fail++; $display("FAIL weak_sym_count: got %0d want 3", sv_wk.size()); end
    for (int k = 0; k < 3 && k < sv_wk.size(); k++) begin
      n_chk++; if (sv_wk[k] !== expw[k]) begin n_fail++; $display("FAIL weak_flag[%0d]: got %b want %b", k, sv_wk[k], expw[k]); end
      n_chk++; if (sv_dib[k] !== expd[k]) begin n_fail++; $display("FAIL weak_dibit[%0d]: got %b want %b", k, sv_dib[k], expd[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_diff();
    test_gaps();
    test_reset_mid();
    test_zero_sign();
    test_weak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
